// File: rtl/des_pkg.sv
// ---------------------------------------------------------------------------
// des_pkg
// Shared constants for the iterative DES key schedule:
//   - PC1_TAB  : 56-entry key permutation (DES bit numbers, 1 = key MSB)
//   - PC2_TAB  : 48-entry compression permutation (C/D bit numbers, 1 = MSB)
//   - SHIFT_TAB: per-round left-rotate amounts for K1..K16
//   - ST_IDLE / ST_RUN sequencer state encoding
//   - rotl28 / rotr28 helpers for the independent 28-bit C and D halves
// No ports (package).
// ---------------------------------------------------------------------------
package des_pkg;

    localparam int KEY_W      = 64;
    localparam int RK_W       = 48;
    localparam int NUM_ROUNDS = 16;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Entry j gives the DES key bit (1..64) that lands in C/D bit j+1.
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    // Entry j gives the C/D bit (1..56) that lands in round-key bit j+1.
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // Entry k-1 is the rotate amount that produces round k from round k-1.
    localparam logic [1:0] SHIFT_TAB [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Rotate amount for schedule index k (1..16).
    function automatic logic [1:0] shift_of(input logic [4:0] k);
        logic [3:0] idx;
        idx = 4'(k - 5'd1);
        return SHIFT_TAB[idx];
    endfunction

    // DES bit 1 sits at the MSB, so a DES left shift is a left rotate here.
    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        logic [27:0] r;
        case (n)
            2'd2:    r = {x[25:0], x[27:26]};
            default: r = {x[26:0], x[27]};
        endcase
        return r;
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        logic [27:0] r;
        case (n)
            2'd2:    r = {x[1:0], x[27:2]};
            default: r = {x[0], x[27:1]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/des_pc2.sv
// ---------------------------------------------------------------------------
// des_pc2
// Purely combinational DES PC2 compression (56 -> 48 bits).
// Ports:
//   cd_i [55:0] : {C,D}, bit 55 = C/D bit 1
//   rk_o [47:0] : round key, bit 47 = round-key bit 1
// ---------------------------------------------------------------------------
module des_pc2
    import des_pkg::*;
(
    input  logic [55:0] cd_i,
    output logic [47:0] rk_o
);

    // C/D bits 9,18,22,25,35,38,43,54 are discarded by PC2.
    logic pc2_unused;
    assign pc2_unused = ^{cd_i[47], cd_i[38], cd_i[34], cd_i[31],
                          cd_i[21], cd_i[18], cd_i[13], cd_i[2]};

    always_comb begin
        rk_o = '0;
        for (int j = 0; j < 48; j++) begin
            rk_o[47 - j] = cd_i[56 - PC2_TAB[j]];
        end
    end

endmodule

// File: rtl/des_key_sequencer.sv
// ---------------------------------------------------------------------------
// des_key_sequencer
// Iterative DES round-key generator. One 64-bit key per job; the 16 round
// keys are emitted one per handshake in encrypt (K1..K16) or decrypt
// (K16..K1) order from a single C/D register pair and one PC2 network.
// Ports:
//   clk, rst_n   : rising-edge clock, asynchronous active-low reset
//   start        : job request, accepted only while busy = 0
//   decrypt      : order select sampled with start (1 = K16..K1)
//   key [63:0]   : DES key, bit 63 = DES bit 1, parity bits ignored
//   busy         : job in progress
//   rk [47:0]    : current round key (PC2 of the C/D registers)
//   rk_num [4:0] : schedule index (K number) of rk
//   rk_valid     : rk / rk_num valid
//   rk_ready     : consumer accepts rk this cycle
//   done         : one-cycle pulse after the 16th key is accepted
//   dbg_state_o  : current sequencer state (ST_IDLE / ST_RUN)
//
// Handshake: a key transfers on every rising edge where rk_valid = 1 and
// rk_ready = 1. While rk_valid = 1 and rk_ready = 0, rk and rk_num are held
// unchanged; rk_valid never drops until the key has been accepted.
// ---------------------------------------------------------------------------
module des_key_sequencer
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic [63:0] key,
    output logic        busy,
    output logic [47:0] rk,
    output logic [4:0]  rk_num,
    output logic        rk_valid,
    input  logic        rk_ready,
    output logic        done,
    output logic [0:0]  dbg_state_o
);

    logic [0:0]  state_q,  state_d;
    logic        dir_q,    dir_d;
    logic [27:0] c_q,      c_d;
    logic [27:0] d_q,      d_d;
    logic [4:0]  cnt_q,    cnt_d;
    logic [4:0]  rk_num_q, rk_num_d;
    logic        done_q,   done_d;

    logic [55:0] cd0;

    // Parity bits (DES bits 8,16,...,64) never reach PC1.
    logic parity_unused;
    assign parity_unused = ^{key[56], key[48], key[40], key[32],
                             key[24], key[16], key[8],  key[0]};

    // PC1 is only needed at load time, so it is kept local to this block.
    always_comb begin
        cd0 = '0;
        for (int j = 0; j < 56; j++) begin
            cd0[55 - j] = key[64 - PC1_TAB[j]];
        end
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        c_d      = c_q;
        d_d      = d_q;
        cnt_d    = cnt_q;
        rk_num_d = rk_num_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    dir_d   = decrypt;
                    cnt_d   = 5'd1;
                    state_d = ST_RUN;
                    if (decrypt) begin
                        // Total rotation over a job is 28, so C0D0 is C16D16.
                        c_d      = cd0[55:28];
                        d_d      = cd0[27:0];
                        rk_num_d = 5'd16;
                    end else begin
                        c_d      = rotl28(cd0[55:28], 2'd1);
                        d_d      = rotl28(cd0[27:0], 2'd1);
                        rk_num_d = 5'd1;
                    end
                end
            end

            ST_RUN: begin
                if (rk_ready) begin
                    if (cnt_q == 5'd16) begin
                        // C/D are left untouched so an encrypt job ends on C16D16.
                        state_d  = ST_IDLE;
                        done_d   = 1'b1;
                        cnt_d    = 5'd0;
                        rk_num_d = 5'd0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                        if (dir_q) begin
                            // Undo the shift that produced the current round.
                            c_d      = rotr28(c_q, shift_of(rk_num_q));
                            d_d      = rotr28(d_q, shift_of(rk_num_q));
                            rk_num_d = rk_num_q - 5'd1;
                        end else begin
                            c_d      = rotl28(c_q, shift_of(rk_num_q + 5'd1));
                            d_d      = rotl28(d_q, shift_of(rk_num_q + 5'd1));
                            rk_num_d = rk_num_q + 5'd1;
                        end
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            dir_q    <= 1'b0;
            c_q      <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            rk_num_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            c_q      <= c_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
            rk_num_q <= rk_num_d;
            done_q   <= done_d;
        end
    end

    des_pc2 u_pc2 (
        .cd_i ({c_q, d_q}),
        .rk_o (rk)
    );

    assign busy        = (state_q == ST_RUN);
    assign rk_valid    = (state_q == ST_RUN);
    assign rk_num      = rk_num_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_des_key_sequencer.sv
// ---------------------------------------------------------------------------
// tb_des_key_sequencer
// Self-checking bench for des_key_sequencer. Expected round keys come from a
// direct DES key-schedule model: PC1 on DES bit numbers, cumulative rotation
// of C and D by the summed shift amounts, then PC2.
// ---------------------------------------------------------------------------
module tb_des_key_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        decrypt;
    logic [63:0] key;
    logic        busy;
    logic [47:0] rk;
    logic [4:0]  rk_num;
    logic        rk_valid;
    logic        rk_ready;
    logic        done;
    logic [0:0]  dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [52:0] exp_q[$];
    logic [52:0] obs_seq [16];

    localparam logic [63:0] TV_KEY = 64'h133457799BBCDFF1;
    localparam logic [63:0] PARITY = 64'h0101010101010101;
    localparam logic [52:0] TV_K1  = {5'd1,  48'h1B02EFFC7072};
    localparam logic [52:0] TV_K2  = {5'd2,  48'h79AED9DBC9E5};
    localparam logic [52:0] TV_K16 = {5'd16, 48'hCB3D8B0E17F5};

    localparam int M_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int M_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int M_SHIFT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    des_key_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .decrypt     (decrypt),
        .key         (key),
        .busy        (busy),
        .rk          (rk),
        .rk_num      (rk_num),
        .rk_valid    (rk_valid),
        .rk_ready    (rk_ready),
        .done        (done),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    // Round key K(n) straight from the DES key-schedule definition.
    function automatic logic [47:0] ref_key(input logic [63:0] k, input int n);
        logic [56:1] cd;
        logic [56:1] r;
        logic [47:0] o;
        int tot;
        tot = 0;
        for (int i = 1; i <= n; i++) tot += M_SHIFT[i-1];
        for (int j = 1; j <= 56; j++) cd[j] = k[64 - M_PC1[j-1]];
        for (int i = 1; i <= 28; i++) begin
            r[i]      = cd[((i - 1 + tot) % 28) + 1];
            r[28 + i] = cd[28 + ((i - 1 + tot) % 28) + 1];
        end
        o = '0;
        for (int j = 1; j <= 48; j++) o[48 - j] = r[M_PC2[j-1]];
        return o;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Runs one job from the current (posedge+1) point in IDLE. Returns in the
    // done cycle, or right after reset release when abort_at >= 0.
    task automatic run_job(input logic [63:0] k, input logic dec, input int ready_pct,
                           input bit hold_start, input bit inject, input int abort_at,
                           input string tag);
        int accepts;
        int cyc;
        bit rdy;
        bit injected;
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            int n;
            n = dec ? 16 - i : i + 1;
            exp_q.push_back({5'(n), ref_key(k, n)});
        end
        start   = 1'b1;
        decrypt = dec;
        key     = k;
        cycle();
        check({tag, " first_valid"}, 64'(rk_valid), 64'd1);
        check({tag, " no_done_at_start"}, 64'(done), 64'd0);
        accepts  = 0;
        cyc      = 1;
        injected = 1'b0;
        while (accepts < 16 && cyc < 400) begin
            start   = hold_start;
            decrypt = ~dec;
            key     = {$urandom, $urandom};
            if (inject && accepts == 4 && !injected) begin
                start    = 1'b1;
                injected = 1'b1;
            end
            if (abort_at == accepts) begin
                rst_n = 1'b0;
                #1;
                check({tag, " rst_busy"},   64'(busy),     64'd0);
                check({tag, " rst_valid"},  64'(rk_valid), 64'd0);
                check({tag, " rst_done"},   64'(done),     64'd0);
                check({tag, " rst_rk_num"}, 64'(rk_num),   64'd0);
                check({tag, " rst_rk"},     64'(rk),       64'd0);
                start    = 1'b0;
                rk_ready = 1'b1;
                cycle();
                cycle();
                rst_n = 1'b1;
                cycle();
                check({tag, " no_done_after_rst"}, 64'(done), 64'd0);
                check({tag, " idle_after_rst"},    64'(busy), 64'd0);
                exp_q.delete();
                return;
            end
            check({tag, " valid"}, 64'(rk_valid), 64'd1);
            check({tag, " key"}, 64'({rk_num, rk}), 64'(exp_q[0]));
            rdy      = ($urandom_range(99) < ready_pct);
            rk_ready = rdy;
            if (rdy) begin
                obs_seq[accepts] = {rk_num, rk};
                void'(exp_q.pop_front());
                accepts++;
            end
            cycle();
            cyc++;
            if (accepts < 16) check({tag, " early_done"}, 64'(done), 64'd0);
        end
        check({tag, " accepts"}, 64'(accepts), 64'd16);
        check({tag, " done"}, 64'(done), 64'd1);
        check({tag, " busy_end"}, 64'(busy), 64'd0);
        check({tag, " valid_end"}, 64'(rk_valid), 64'd0);
        if (ready_pct >= 100) check({tag, " latency"}, 64'(cyc), 64'd17);
        rk_ready = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        decrypt  = 1'b0;
        key      = '0;
        rk_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy",   64'(busy),      64'd0);
        check("reset valid",  64'(rk_valid),  64'd0);
        check("reset done",   64'(done),      64'd0);
        check("reset rk_num", 64'(rk_num),    64'd0);
        check("reset rk",     64'(rk),        64'd0);
        check("reset state",  64'(dbg_state), 64'd0);
        rst_n = 1'b1;
        cycle();
        check("idle no start", 64'(busy), 64'd0);

        // Known-answer encrypt and decrypt runs.
        run_job(TV_KEY, 1'b0, 100, 1'b0, 1'b0, -1, "enc");
        check("enc K1",  64'(obs_seq[0]),  64'(TV_K1));
        check("enc K2",  64'(obs_seq[1]),  64'(TV_K2));
        check("enc K16", 64'(obs_seq[15]), 64'(TV_K16));
        start = 1'b0;
        cycle();
        check("enc done_one_cycle", 64'(done), 64'd0);

        run_job(TV_KEY, 1'b1, 100, 1'b0, 1'b0, -1, "dec");
        check("dec first", 64'(obs_seq[0]),  64'(TV_K16));
        check("dec last",  64'(obs_seq[15]), 64'(TV_K1));
        start = 1'b0;
        cycle();

        // Random back-pressure on random keys, both orders.
        for (int j = 0; j < 4; j++) begin
            run_job({$urandom, $urandom}, j[0], 40, 1'b0, 1'b0, -1, "bp");
            start = 1'b0;
            cycle();
        end

        // Start with a different key during round 5 is ignored.
        run_job({$urandom, $urandom}, 1'b0, 70, 1'b0, 1'b1, -1, "inject");
        start = 1'b0;
        cycle();

        // Parity bits do not affect the schedule.
        run_job(TV_KEY ^ PARITY, 1'b0, 100, 1'b0, 1'b0, -1, "parity");
        check("parity K1",  64'(obs_seq[0]),  64'(TV_K1));
        check("parity K16", 64'(obs_seq[15]), 64'(TV_K16));
        start = 1'b0;
        cycle();

        // Reset during round 9, then a clean job.
        run_job({$urandom, $urandom}, 1'b1, 100, 1'b0, 1'b0, 8, "abort");
        run_job({$urandom, $urandom}, 1'b0, 100, 1'b0, 1'b0, -1, "post_abort");
        start = 1'b0;
        cycle();

        // Back-to-back jobs with start held high and alternating order.
        for (int j = 0; j < 4; j++) begin
            run_job({$urandom, $urandom}, j[0], 100, 1'b1, 1'b0, -1, "b2b");
        end
        start = 1'b0;
        cycle();
        check("b2b final done", 64'(done), 64'd0);
        check("b2b final busy", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/des_key_sequencer.md
Name: des_key_sequencer

Overview:
- Iterative DES round-key generator. Accepts one 64-bit key per job and emits the 16 48-bit round keys, one per accepted handshake, in either encrypt order (K1..K16) or decrypt order (K16..K1).
- Sits between the key input register and an iterative DES round engine.
- Replaces the fully unrolled 16-key combinational scheduler with one C/D register pair, one PC2 network and a round counter.

Parameters:
- KEY_W, 64, input key width (fixed; documentation only).
- RK_W, 48, round-key width (fixed; documentation only).
- NUM_ROUNDS, 16, rounds per job (fixed; documentation only).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  job request; accepted only when busy=0.
- decrypt  input  1  order select; 0 = K1..K16, 1 = K16..K1. Sampled with start.
- key  input  64  DES key, bit numbering [64:1], MSB = DES bit 1. Parity bits 8,16,...,64 are ignored. Sampled with start.
- busy  output  1  job in progress.
- rk  output  48  current round key, [48:1] in DES PC2 order.
- rk_num  output  5  schedule index of rk, 1..16 (K number, not emission count).
- rk_valid  output  1  rk/rk_num valid.
- rk_ready  input  1  consumer accepts rk this cycle.
- done  output  1  one-cycle pulse after the 16th key is accepted.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; C,D=0; cnt=0; busy=0, rk_valid=0, done=0, rk_num=0. rk=PC2(0)=0. Reset mid-job abandons it with no done pulse.
- FSM states are IDLE and RUN.
- IDLE:
  - On start=1 at edge T: capture decrypt into dir_q and compute {C0,D0}=PC1(key).
  - Encrypt loads {C,D}=rotl({C0,D0},1) (this is C1D1) with rk_num=1.
  - Decrypt loads {C,D}={C0,D0} (equal to C16D16) with rk_num=16.
  - cnt=1; go to RUN.
  - start=0 in IDLE: no change.
- RUN:
  - busy=1 and rk_valid=1 continuously; first valid key in cycle T+1.
  - rk = PC2({C,D}), combinational from registers. No pipeline bubble between keys.
  - Hold: rk_valid=1 and rk_ready=0 leaves rk, rk_num and C/D stable (AXI-style; the consumer may stall indefinitely).
  - Accept: rk_valid=1 and rk_ready=1 with cnt<16 gives cnt+=1 and:
    - Encrypt: rk_num+=1; C,D each rotate left by SHIFT[rk_num+1].
    - Decrypt: C,D each rotate right by SHIFT[rk_num]; rk_num-=1.
  - SHIFT[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. C and D are rotated independently as 28-bit values.
  - Accept with cnt=16: next cycle busy=0, rk_valid=0, done=1 for exactly one cycle; return to IDLE.
- start while busy=1 is ignored (not queued); key and decrypt changes mid-job have no effect.
- start in the done cycle is accepted (FSM is already IDLE), so back-to-back jobs run 17 cycles apart with an always-ready consumer.
- Latency: start to first rk_valid is 1 cycle. Start to done is 17 cycles with rk_ready held high.
- Invariants:
  - rk_num is always 1..16 while rk_valid=1.
  - After a full job, C/D equals C16D16 for encrypt, which is the rotl28 identity applied to C0D0 (total shift 28).

Decomposition:
- Package des_pkg holds:
  - PC1 table (56 entries) and PC2 table (48 entries) as localparam index arrays.
  - SHIFT table.
  - State encoding ST_IDLE/ST_RUN.
  - Functions rotl28/rotr28.
- Sub-module des_pc2: purely combinational 56-to-48 permutation, reusable by the round engine's tests.
- PC1 is inlined since it is used only at load.

Test Plan:
- Encrypt, key=64'h133457799BBCDFF1, rk_ready=1: rk_valid rises T+1. (rk_num,rk) = (1,48'h1B02EFFC7072), (2,48'h79AED9DBC9E5), ..., (16,48'hCB3D8B0E17F5). done pulses at T+17.
- Decrypt, same key: first (16,48'hCB3D8B0E17F5), last (1,48'h1B02EFFC7072). The full sequence is the exact reverse of the encrypt run.
- Back-pressure: random rk_ready (~40% duty) gives the same 16 keys in the same order, with rk/rk_num stable on every stalled cycle and done only after the 16th accept.
- start asserted with a different key at round 5: ignored, and the output sequence matches the original key. Parity-bit flips on key (bits 8,16,...) leave all keys unchanged.
- rst_n pulsed low mid-job at round 9: outputs clear immediately (async) and no done pulse. A new start after release produces a correct full sequence.
- Back-to-back: start held high with alternating decrypt: second job's first key appears the cycle after done, jobs repeat every 17 cycles, and the order alternates correctly.
